// File: rtl/game_pkg.sv
// Shared encodings between the game controller FSM and the player status block.
package game_pkg;

  typedef enum logic [2:0] {
    GS_START     = 3'd0,
    GS_PLAYING   = 3'd1,
    GS_LEVEL_INC = 3'd2,
    GS_WORLD_INC = 3'd3,
    GS_LIVES_DEC = 3'd4,
    GS_LOSE_GAME = 3'd5,
    GS_WIN_GAME  = 3'd6
  } game_status_e;

  typedef enum logic [1:0] {
    PLAYING    = 2'd0,
    LEVEL_PASS = 2'd1,
    DIED       = 2'd2
  } player_status_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_HAZARD  = 2'd1,
    CAUSE_FALL    = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } death_cause_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRACE = 3'd1,
    ST_ARMED = 3'd2,
    ST_PASS  = 3'd3,
    ST_DEAD  = 3'd4
  } ps_state_e;

endpackage

// File: rtl/level_timer.sv
// Loadable 8-bit saturating down-counter holding the remaining level time.
module level_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_run,
  input  logic       i_freeze,
  input  logic       i_tick,
  output logic [7:0] o_time_left,
  output logic       o_timeout
);

  logic [7:0] r_count;
  logic       w_dec;

  assign w_dec       = i_run && i_tick && !i_freeze;
  assign o_time_left = r_count;
  // Expiry is flagged on the tick that would take the count to zero, not one cycle later.
  assign o_timeout   = ((r_count == 8'd1) && i_tick) || (r_count == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (w_dec && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

endmodule

// File: rtl/player_status_gen.sv
// Per-level player status FSM: grace window, hazard/fall/timeout deaths and level pass,
// held until the game controller acknowledges by leaving the playing state.
module player_status_gen
  import game_pkg::*;
#(
  parameter int unsigned TIME_LIMIT   = 200,
  parameter int unsigned GRACE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] gameStatus,
  input  logic       goalHit,
  input  logic       hazardHit,
  input  logic       fallOut,
  input  logic       timerTick,
  output logic [1:0] playerStatus,
  output logic [1:0] deathCause,
  output logic [7:0] timeLeft
);

  logic [1:0] r_rst_sync;
  logic       w_rst_n;
  ps_state_e  r_state;
  logic [7:0] r_grace;
  logic       w_play;
  logic       w_load;
  logic       w_run;
  logic       w_timeout;

  // Assertion passes straight through the synchroniser's async clear; release takes two edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_sync <= '0;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  assign w_play = (gameStatus == GS_PLAYING);
  assign w_load = (r_state == ST_IDLE) && w_play;
  assign w_run  = ((r_state == ST_GRACE) || (r_state == ST_ARMED)) && w_play;

  level_timer u_level_timer (
    .clk         (clk),
    .rst_n       (w_rst_n),
    .i_load      (w_load),
    .i_load_val  (8'(TIME_LIMIT)),
    .i_run       (w_run),
    .i_freeze    (goalHit),
    .i_tick      (timerTick),
    .o_time_left (timeLeft),
    .o_timeout   (w_timeout)
  );

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= ST_IDLE;
      r_grace      <= '0;
      playerStatus <= PLAYING;
      deathCause   <= CAUSE_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          playerStatus <= PLAYING;
          if (w_play) begin
            r_state    <= ST_GRACE;
            r_grace    <= 8'(GRACE_CYCLES);
            deathCause <= CAUSE_NONE;
          end
        end
        ST_GRACE: begin
          if (!w_play) begin
            r_state <= ST_IDLE;
          end else if (goalHit) begin
            r_state      <= ST_PASS;
            playerStatus <= LEVEL_PASS;
          end else if (w_timeout) begin
            r_state      <= ST_DEAD;
            playerStatus <= DIED;
            deathCause   <= CAUSE_TIMEOUT;
          end else begin
            r_grace <= r_grace - 8'd1;
            if (r_grace <= 8'd1) begin
              r_state <= ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          if (!w_play) begin
            r_state <= ST_IDLE;
          end else if (goalHit) begin
            r_state      <= ST_PASS;
            playerStatus <= LEVEL_PASS;
          end else if (hazardHit) begin
            r_state      <= ST_DEAD;
            playerStatus <= DIED;
            deathCause   <= CAUSE_HAZARD;
          end else if (fallOut) begin
            r_state      <= ST_DEAD;
            playerStatus <= DIED;
            deathCause   <= CAUSE_FALL;
          end else if (w_timeout) begin
            r_state      <= ST_DEAD;
            playerStatus <= DIED;
            deathCause   <= CAUSE_TIMEOUT;
          end
        end
        ST_PASS, ST_DEAD: begin
          if (!w_play) begin
            r_state      <= ST_IDLE;
            playerStatus <= PLAYING;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          playerStatus <= PLAYING;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_status_gen.sv
// Directed bench for player_status_gen: default instance plus a short-time-limit instance.
module tb_player_status_gen;

  logic       clk;
  logic       reset;
  logic [2:0] gameStatus;
  logic       goalHit;
  logic       hazardHit;
  logic       fallOut;
  logic       timerTick;
  logic [1:0] playerStatus,  deathCause;
  logic [7:0] timeLeft;
  logic [1:0] playerStatus3, deathCause3;
  logic [7:0] timeLeft3;

  int n_cmp  = 0;
  int n_fail = 0;

  player_status_gen dut (
    .clk          (clk),
    .reset        (reset),
    .gameStatus   (gameStatus),
    .goalHit      (goalHit),
    .hazardHit    (hazardHit),
    .fallOut      (fallOut),
    .timerTick    (timerTick),
    .playerStatus (playerStatus),
    .deathCause   (deathCause),
    .timeLeft     (timeLeft)
  );

  player_status_gen #(.TIME_LIMIT(3), .GRACE_CYCLES(4)) dut3 (
    .clk          (clk),
    .reset        (reset),
    .gameStatus   (gameStatus),
    .goalHit      (goalHit),
    .hazardHit    (hazardHit),
    .fallOut      (fallOut),
    .timerTick    (timerTick),
    .playerStatus (playerStatus3),
    .deathCause   (deathCause3),
    .timeLeft     (timeLeft3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Enter a level from IDLE and run out the 16-cycle grace window of the default instance.
  task automatic start_armed();
    gameStatus = 3'd1;
    step(1);
    step(16);
  endtask

  task automatic test_reset();
    reset = 1'b0; gameStatus = 3'd0;
    goalHit = 0; hazardHit = 0; fallOut = 0; timerTick = 0;
    step(3);
    n_cmp++; if (playerStatus !== 2'd0) begin $display("FAIL rst_status got %0d want 0", playerStatus); n_fail++; end
    n_cmp++; if (deathCause !== 2'd0) begin $display("FAIL rst_cause got %0d want 0", deathCause); n_fail++; end
    n_cmp++; if (timeLeft !== 8'd0) begin $display("FAIL rst_time got %0d want 0", timeLeft); n_fail++; end
    reset = 1'b1;
    step(3);
  endtask

  task automatic test_goal();
    gameStatus = 3'd1;
    step(1);
    n_cmp++; if (timeLeft !== 8'd200) begin $display("FAIL goal_load got %0d want 200", timeLeft); n_fail++; end
    step(16);
    goalHit = 1; timerTick = 1;
    step(1);
    goalHit = 0;
    n_cmp++; if (playerStatus !== 2'd1) begin $display("FAIL goal_status got %0d want 1", playerStatus); n_fail++; end
    n_cmp++; if (timeLeft !== 8'd200) begin $display("FAIL goal_freeze got %0d want 200", timeLeft); n_fail++; end
    step(3);
    timerTick = 0;
    n_cmp++; if (timeLeft !== 8'd200) begin $display("FAIL pass_freeze got %0d want 200", timeLeft); n_fail++; end
    n_cmp++; if (playerStatus !== 2'd1) begin $display("FAIL pass_hold got %0d want 1", playerStatus); n_fail++; end
    gameStatus = 3'd2;
    step(1);
    n_cmp++; if (playerStatus !== 2'd0) begin $display("FAIL pass_ack got %0d want 0", playerStatus); n_fail++; end
    n_cmp++; if (timeLeft !== 8'd200) begin $display("FAIL idle_time_hold got %0d want 200", timeLeft); n_fail++; end
  endtask

  task automatic test_hazard_grace();
    gameStatus = 3'd1;
    step(1);
    step(3);
    hazardHit = 1; fallOut = 1;
    step(1);
    hazardHit = 0; fallOut = 0;
    n_cmp++; if (playerStatus !== 2'd0) begin $display("FAIL grace_ignore got %0d want 0", playerStatus); n_fail++; end
    step(12);
    n_cmp++; if (playerStatus !== 2'd0) begin $display("FAIL grace_end got %0d want 0", playerStatus); n_fail++; end
    hazardHit = 1; fallOut = 1;
    step(1);
    hazardHit = 0; fallOut = 0;
    n_cmp++; if (playerStatus !== 2'd2) begin $display("FAIL hazard_status got %0d want 2", playerStatus); n_fail++; end
    n_cmp++; if (deathCause !== 2'd1) begin $display("FAIL hazard_cause got %0d want 1", deathCause); n_fail++; end
  endtask

  task automatic test_dead_hold();
    step(50);
    n_cmp++; if (playerStatus !== 2'd2) begin $display("FAIL dead_hold got %0d want 2", playerStatus); n_fail++; end
    gameStatus = 3'd4;
    step(1);
    n_cmp++; if (playerStatus !== 2'd0) begin $display("FAIL dead_ack got %0d want 0", playerStatus); n_fail++; end
    n_cmp++; if (deathCause !== 2'd1) begin $display("FAIL idle_cause_hold got %0d want 1", deathCause); n_fail++; end
    step(2);
    n_cmp++; if (playerStatus !== 2'd0) begin $display("FAIL idle_stay got %0d want 0", playerStatus); n_fail++; end
  endtask

  task automatic test_fall();
    gameStatus = 3'd1;
    step(1);
    n_cmp++; if (deathCause !== 2'd0) begin $display("FAIL reenter_cause got %0d want 0", deathCause); n_fail++; end
    n_cmp++; if (timeLeft !== 8'd200) begin $display("FAIL reenter_time got %0d want 200", timeLeft); n_fail++; end
    step(16);
    fallOut = 1; timerTick = 1;
    step(1);
    fallOut = 0; timerTick = 0;
    n_cmp++; if (playerStatus !== 2'd2) begin $display("FAIL fall_status got %0d want 2", playerStatus); n_fail++; end
    n_cmp++; if (deathCause !== 2'd2) begin $display("FAIL fall_cause got %0d want 2", deathCause); n_fail++; end
    n_cmp++; if (timeLeft !== 8'd199) begin $display("FAIL fall_time got %0d want 199", timeLeft); n_fail++; end
    gameStatus = 3'd2;
    step(1);
  endtask

  task automatic test_goal_priority();
    start_armed();
    goalHit = 1; hazardHit = 1;
    step(1);
    goalHit = 0; hazardHit = 0;
    n_cmp++; if (playerStatus !== 2'd1) begin $display("FAIL prio_status got %0d want 1", playerStatus); n_fail++; end
    n_cmp++; if (deathCause !== 2'd0) begin $display("FAIL prio_cause got %0d want 0", deathCause); n_fail++; end
    gameStatus = 3'd2;
    step(1);
  endtask

  task automatic test_abort();
    start_armed();
    gameStatus = 3'd0; hazardHit = 1;
    step(1);
    hazardHit = 0;
    n_cmp++; if (playerStatus !== 2'd0) begin $display("FAIL abort_status got %0d want 0", playerStatus); n_fail++; end
    n_cmp++; if (deathCause !== 2'd0) begin $display("FAIL abort_cause got %0d want 0", deathCause); n_fail++; end
    step(2);
    n_cmp++; if (playerStatus !== 2'd0) begin $display("FAIL abort_idle got %0d want 0", playerStatus); n_fail++; end
  endtask

  task automatic test_reset_mid_dead();
    start_armed();
    hazardHit = 1;
    step(1);
    hazardHit = 0;
    n_cmp++; if (playerStatus !== 2'd2) begin $display("FAIL pre_rst_dead got %0d want 2", playerStatus); n_fail++; end
    reset = 1'b0;
    #1;
    n_cmp++; if (playerStatus !== 2'd0) begin $display("FAIL async_rst_status got %0d want 0", playerStatus); n_fail++; end
    n_cmp++; if (deathCause !== 2'd0) begin $display("FAIL async_rst_cause got %0d want 0", deathCause); n_fail++; end
    n_cmp++; if (timeLeft !== 8'd0) begin $display("FAIL async_rst_time got %0d want 0", timeLeft); n_fail++; end
    step(2);
    reset = 1'b1;
    step(2);
    n_cmp++; if (timeLeft !== 8'd0) begin $display("FAIL rst_sync_release got %0d want 0", timeLeft); n_fail++; end
    step(1);
    n_cmp++; if (timeLeft !== 8'd200) begin $display("FAIL post_rst_load got %0d want 200", timeLeft); n_fail++; end
    n_cmp++; if (playerStatus !== 2'd0) begin $display("FAIL post_rst_status got %0d want 0", playerStatus); n_fail++; end
  endtask

  // Continues from the level just started above: dut3 loaded 3 on the same edge.
  task automatic test_timeout();
    n_cmp++; if (timeLeft3 !== 8'd3) begin $display("FAIL to_load got %0d want 3", timeLeft3); n_fail++; end
    timerTick = 1; step(1); timerTick = 0;
    n_cmp++; if (timeLeft3 !== 8'd2) begin $display("FAIL to_tick1 got %0d want 2", timeLeft3); n_fail++; end
    step(1);
    timerTick = 1; step(1); timerTick = 0;
    n_cmp++; if (timeLeft3 !== 8'd1) begin $display("FAIL to_tick2 got %0d want 1", timeLeft3); n_fail++; end
    n_cmp++; if (playerStatus3 !== 2'd0) begin $display("FAIL to_alive got %0d want 0", playerStatus3); n_fail++; end
    step(1);
    timerTick = 1; step(1); timerTick = 0;
    n_cmp++; if (timeLeft3 !== 8'd0) begin $display("FAIL to_tick3 got %0d want 0", timeLeft3); n_fail++; end
    n_cmp++; if (playerStatus3 !== 2'd2) begin $display("FAIL to_status got %0d want 2", playerStatus3); n_fail++; end
    n_cmp++; if (deathCause3 !== 2'd3) begin $display("FAIL to_cause got %0d want 3", deathCause3); n_fail++; end
    n_cmp++; if (timeLeft !== 8'd197) begin $display("FAIL to_main_time got %0d want 197", timeLeft); n_fail++; end
    n_cmp++; if (playerStatus !== 2'd0) begin $display("FAIL to_main_status got %0d want 0", playerStatus); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_goal();
    test_hazard_grace();
    test_dead_hold();
    test_fall();
    test_goal_priority();
    test_abort();
    test_reset_mid_dead();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
